// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcodes, FSM state encoding and fixed results shared by the
//           ALU command issuer and its neighbours.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [8:0] DIV0_RESULT = 9'h1FF;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
// ============================================================================
// alu_cmd_issuer : registers tagged commands onto the ALU inputs, captures
//                  the ALU result and returns it with flags over valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [3:0]       cmd_sel,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [8:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [8:0]       rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [15:0]      ops_done
);

    localparam logic [1:0] LAST_WAIT = 2'(ALU_LAT);

    logic [1:0]       state_q, state_d;
    logic [1:0]       wait_q;
    logic [7:0]       alu_a_q, alu_b_q;
    logic [3:0]       alu_sel_q;
    logic [TAG_W-1:0] tag_q;
    logic [8:0]       rsp_result_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_zero_q, rsp_err_q;
    logic [15:0]      ops_done_q;

    logic cmd_hs, rsp_hs, last_exec, div0;

    assign cmd_hs    = cmd_valid && cmd_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign last_exec = (state_q == ST_EXEC) && (wait_q == LAST_WAIT);
    assign div0      = (alu_sel_q == OP_DIV) && (alu_b_q == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_hs) state_d = ST_EXEC;
            ST_EXEC: if (last_exec) state_d = ST_RESP;
            ST_RESP: if (rsp_hs) state_d = cmd_hs ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is the only combinational path: RESP may hand over to a new
    // command in the same cycle its response is taken.
    always_comb begin
        cmd_ready = !rst && ((state_q == ST_IDLE) ||
                             ((state_q == ST_RESP) && rsp_ready));
        rsp_valid = (state_q == ST_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q    <= 2'd0;
            alu_a_q   <= 8'd0;
            alu_b_q   <= 8'd0;
            alu_sel_q <= 4'd0;
            tag_q     <= '0;
        end else if (cmd_hs) begin
            wait_q    <= 2'd0;
            alu_a_q   <= cmd_a;
            alu_b_q   <= cmd_b;
            alu_sel_q <= cmd_sel;
            tag_q     <= cmd_tag;
        end else if (state_q == ST_EXEC && !last_exec) begin
            wait_q    <= wait_q + 2'd1;
        end
    end

    // An undefined divide result is never captured; a fixed marker is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result_q <= 9'd0;
            rsp_tag_q    <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else if (last_exec) begin
            rsp_tag_q <= tag_q;
            if (div0) begin
                rsp_result_q <= DIV0_RESULT;
                rsp_zero_q   <= 1'b0;
                rsp_err_q    <= 1'b1;
            end else begin
                rsp_result_q <= alu_result;
                rsp_zero_q   <= (alu_result == 9'd0);
                rsp_err_q    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_done_q <= 16'd0;
        end else if (rsp_hs) begin
            ops_done_q <= ops_done_q + 16'd1;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign ops_done   = ops_done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
// ============================================================================
// tb_alu_cmd_issuer : directed bench for alu_cmd_issuer with ALU_LAT=0 and 2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference ALU sitting beside each issuer
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (s)
            4'b0000: return {1'b0, a} + {1'b0, b};
            4'b0001: return {1'b0, a} - {1'b0, b};
            4'b0010: return p[8:0];
            4'b0011: return (b == 8'd0) ? 9'h000 : {1'b0, a / b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    // ---------------- instance 0: ALU_LAT = 0 ----------------
    logic       rst0, cmd_valid0, cmd_ready0, rsp_valid0, rsp_ready0, rsp_zero0, rsp_err0;
    logic [7:0] cmd_a0, cmd_b0, alu_a0, alu_b0;
    logic [3:0] cmd_sel0, alu_sel0, cmd_tag0, rsp_tag0;
    logic [8:0] alu_res0, rsp_result0;
    logic [15:0] ops_done0;
    assign alu_res0 = alu_f(alu_a0, alu_b0, alu_sel0);

    alu_cmd_issuer #(.TAG_W(4), .ALU_LAT(0)) dut0 (
        .clk(clk), .rst(rst0),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_a(cmd_a0), .cmd_b(cmd_b0), .cmd_sel(cmd_sel0), .cmd_tag(cmd_tag0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0), .alu_result(alu_res0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_result(rsp_result0), .rsp_tag(rsp_tag0),
        .rsp_zero(rsp_zero0), .rsp_err(rsp_err0), .ops_done(ops_done0)
    );

    // ---------------- instance 1: ALU_LAT = 2 ----------------
    logic       rst1, cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1, rsp_zero1, rsp_err1;
    logic [7:0] cmd_a1, cmd_b1, alu_a1, alu_b1;
    logic [3:0] cmd_sel1, alu_sel1, cmd_tag1, rsp_tag1;
    logic [8:0] alu_res1, rsp_result1;
    logic [15:0] ops_done1;
    assign alu_res1 = alu_f(alu_a1, alu_b1, alu_sel1);

    alu_cmd_issuer #(.TAG_W(4), .ALU_LAT(2)) dut1 (
        .clk(clk), .rst(rst1),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_sel(cmd_sel1), .cmd_tag(cmd_tag1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_result(alu_res1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_result(rsp_result1), .rsp_tag(rsp_tag1),
        .rsp_zero(rsp_zero1), .rsp_err(rsp_err1), .ops_done(ops_done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a command on instance 0; returns 1ns after the handshake edge.
    task automatic send0(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] s, input logic [3:0] tg);
        int k;
        cmd_a0 = a; cmd_b0 = b; cmd_sel0 = s; cmd_tag0 = tg; cmd_valid0 = 1'b1;
        k = 0;
        while (!cmd_ready0 && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) check("send_timeout", 32'd1, 32'd0);
        tick();
        cmd_valid0 = 1'b0;
    endtask

    task automatic run_one(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] s, input logic [3:0] tg,
                           input logic [8:0] er, input logic ez, input logic ee);
        send0(a, b, s, tg);
        check({nm, "_exec_nvalid"}, 32'(rsp_valid0), 32'd0);
        tick();
        check({nm, "_valid"}, 32'(rsp_valid0), 32'd1);
        check({nm, "_result"}, 32'(rsp_result0), 32'(er));
        check({nm, "_tag"}, 32'(rsp_tag0), 32'(tg));
        check({nm, "_zero"}, 32'(rsp_zero0), 32'(ez));
        check({nm, "_err"}, 32'(rsp_err0), 32'(ee));
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
        check({nm, "_idle_ready"}, 32'(cmd_ready0), 32'd1);
    endtask

    initial begin
        int rx, idx, last;
        logic bad;
        rst0 = 1'b1; rst1 = 1'b1;
        cmd_valid0 = 0; cmd_a0 = 0; cmd_b0 = 0; cmd_sel0 = 0; cmd_tag0 = 0; rsp_ready0 = 0;
        cmd_valid1 = 0; cmd_a1 = 0; cmd_b1 = 0; cmd_sel1 = 0; cmd_tag1 = 0; rsp_ready1 = 0;
        tick(); tick();
        check("rst_cmd_ready", 32'(cmd_ready0), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
        check("rst_alu_a", 32'(alu_a0), 32'd0);
        check("rst_rsp_result", 32'(rsp_result0), 32'd0);
        check("rst_ops_done", 32'(ops_done0), 32'd0);
        #2 rst0 = 1'b0; rst1 = 1'b0;
        #1 check("rel_cmd_ready", 32'(cmd_ready0), 32'd1);
        tick();

        // ADD 200+100, also confirm operand registers
        send0(8'd200, 8'd100, 4'b0000, 4'd3);
        check("add_alu_a", 32'(alu_a0), 32'd200);
        check("add_alu_b", 32'(alu_b0), 32'd100);
        check("add_exec_nready", 32'(cmd_ready0), 32'd0);
        check("add_exec_nvalid", 32'(rsp_valid0), 32'd0);
        tick();
        check("add_valid", 32'(rsp_valid0), 32'd1);
        check("add_result", 32'(rsp_result0), 32'd300);
        check("add_tag", 32'(rsp_tag0), 32'd3);
        check("add_zero", 32'(rsp_zero0), 32'd0);
        check("add_err", 32'(rsp_err0), 32'd0);
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
        check("add_ops_done", 32'(ops_done0), 32'd1);

        run_one("sub_eq",  8'd5,  8'd5, 4'b0001, 4'd4, 9'd0,   1'b1, 1'b0);
        run_one("sub_neg", 8'd3,  8'd5, 4'b0001, 4'd5, 9'h1FE, 1'b0, 1'b0);
        run_one("mul_trn", 8'd30, 8'd20, 4'b0010, 4'd6, 9'h058, 1'b0, 1'b0);
        run_one("div0",    8'd50, 8'd0, 4'b0011, 4'd7, 9'h1FF, 1'b0, 1'b1);
        run_one("div7",    8'd50, 8'd7, 4'b0011, 4'd8, 9'd7,   1'b0, 1'b0);
        check("ops_after_dir", 32'(ops_done0), 32'd6);

        // Back-to-back: ten commands, rsp_ready held high
        #2 rst0 = 1'b1;
        #1 check("midrst_ops", 32'(ops_done0), 32'd0);
        tick();
        #2 rst0 = 1'b0;
        tick();
        rsp_ready0 = 1'b1;
        idx = 0; rx = 0; last = 0;
        cmd_valid0 = 1'b1; cmd_a0 = 8'd0; cmd_b0 = 8'd1; cmd_sel0 = 4'b0000; cmd_tag0 = 4'd0;
        for (int cyc = 0; cyc < 60 && rx < 10; cyc++) begin
            logic hs;
            hs = cmd_valid0 && cmd_ready0;
            if (rsp_valid0) begin
                check("b2b_tag", 32'(rsp_tag0), 32'(rx));
                check("b2b_result", 32'(rsp_result0), 32'(rx + 1));
                if (rx > 0) check("b2b_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                rx++;
            end
            tick();
            if (hs) begin
                idx++;
                if (idx == 10) cmd_valid0 = 1'b0;
                else begin
                    cmd_a0 = 8'(idx); cmd_tag0 = 4'(idx);
                end
            end
        end
        rsp_ready0 = 1'b0;
        cmd_valid0 = 1'b0;
        check("b2b_count", 32'(rx), 32'd10);
        check("b2b_ops_done", 32'(ops_done0), 32'd10);

        // Back-pressure: response held, new command waiting
        send0(8'd9, 8'd4, 4'b0001, 4'd6);
        tick();
        cmd_valid0 = 1'b1; cmd_a0 = 8'd1; cmd_b0 = 8'd2; cmd_sel0 = 4'b0000; cmd_tag0 = 4'd7;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid0), 32'd1);
            check("stall_result", 32'(rsp_result0), 32'd5);
            check("stall_tag", 32'(rsp_tag0), 32'd6);
            check("stall_nready", 32'(cmd_ready0), 32'd0);
            check("stall_ops", 32'(ops_done0), 32'd10);
            tick();
        end
        rsp_ready0 = 1'b1;
        #1 check("release_ready", 32'(cmd_ready0), 32'd1);
        tick();
        rsp_ready0 = 1'b0; cmd_valid0 = 1'b0;
        check("release_ops", 32'(ops_done0), 32'd11);
        check("release_exec", 32'(rsp_valid0), 32'd0);
        tick();
        check("next_valid", 32'(rsp_valid0), 32'd1);
        check("next_result", 32'(rsp_result0), 32'd3);
        check("next_tag", 32'(rsp_tag0), 32'd7);

        // Instance 1: latency with ALU_LAT=2, then reset in EXEC
        cmd_valid1 = 1'b1; cmd_a1 = 8'd10; cmd_b1 = 8'd20; cmd_sel1 = 4'b0000; cmd_tag1 = 4'd9;
        check("l2_ready", 32'(cmd_ready1), 32'd1);
        tick();
        cmd_valid1 = 1'b0;
        tick(); tick();
        check("l2_nvalid", 32'(rsp_valid1), 32'd0);
        tick();
        check("l2_valid", 32'(rsp_valid1), 32'd1);
        check("l2_result", 32'(rsp_result1), 32'd30);
        check("l2_tag", 32'(rsp_tag1), 32'd9);
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
        check("l2_ops", 32'(ops_done1), 32'd1);

        cmd_valid1 = 1'b1; cmd_a1 = 8'd7; cmd_b1 = 8'd8; cmd_sel1 = 4'b0010; cmd_tag1 = 4'd2;
        tick();
        cmd_valid1 = 1'b0;
        check("l2b_alu_a", 32'(alu_a1), 32'd7);
        tick();
        #2 rst1 = 1'b1;
        #1;
        check("arst_valid", 32'(rsp_valid1), 32'd0);
        check("arst_alu_a", 32'(alu_a1), 32'd0);
        check("arst_alu_sel", 32'(alu_sel1), 32'd0);
        check("arst_ops", 32'(ops_done1), 32'd0);
        check("arst_ready", 32'(cmd_ready1), 32'd0);
        tick();
        #3 rst1 = 1'b0;
        #1 check("arst_rel_ready", 32'(cmd_ready1), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid1) bad = 1'b1;
        end
        check("arst_no_rsp", 32'(bad), 32'd0);
        check("arst_ops_hold", 32'(ops_done1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Sequential front end for the 8-bit combinational ALU. It accepts tagged operation commands over a valid/ready handshake and registers the operands onto the ALU's A/B/ALU_Sel inputs. It then captures the 9-bit ALU_Result and returns it, with flags, over a second valid/ready handshake. It sits between the instruction/command source and the ALU instance, and it screens out division by zero so an undefined divide result is never captured.

## Interface
- TAG_W, 4: width of the command/response tag.
- ALU_LAT, 0: extra settle cycles before capture (0..3). Set it non-zero when the ALU is registered or slow.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  issuer can accept a command.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_sel  in  4  ALU opcode (same encoding as ALU_Sel).
- cmd_tag  in  TAG_W  opaque tag, returned with the response.
- alu_a  out  8  registered operand to ALU A.
- alu_b  out  8  registered operand to ALU B.
- alu_sel  out  4  registered opcode to ALU_Sel.
- alu_result  in  9  ALU_Result from the ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_result  out  9  captured result.
- rsp_tag  out  TAG_W  tag of the command that produced this response.
- rsp_zero  out  1  rsp_result == 0.
- rsp_err  out  1  division by zero; the result is forced.
- ops_done  out  16  count of completed response handshakes.

## Operation
- FSM states:
  - IDLE: cmd_ready=1.
  - EXEC: waits 1+ALU_LAT cycles, counted by a 2-bit wait counter.
  - RESP: rsp_valid=1.
- Handshakes fire when valid && ready in the same cycle.
- IDLE, on a cmd handshake: load alu_a/alu_b/alu_sel and a tag register, clear the wait counter, go to EXEC.
- EXEC:
  - Drive the ALU from the registered operands; do not accept commands.
  - On the last EXEC cycle, capture into the rsp registers and go to RESP.
  - Captured values: rsp_result=alu_result, rsp_zero=(alu_result==0), rsp_err=0.
- Division by zero (alu_sel==4'b0011 and alu_b==0): capture rsp_result=9'h1FF, rsp_err=1, rsp_zero=0. alu_result is ignored.
- RESP:
  - Hold every rsp_* output stable until the rsp handshake.
  - On the rsp handshake: ops_done += 1. ops_done wraps 16'hFFFF -> 0.
  - rsp handshake and no cmd handshake: go to IDLE.
  - rsp handshake and cmd handshake in the same cycle: load the new command and go directly to EXEC.
- cmd_ready = !rst && (state==IDLE || (state==RESP && rsp_ready)). This is the only combinational ready path.
- No arithmetic inside the block. rsp_result is the ALU's 9-bit value as delivered: a product truncated to 9 bits, a borrow visible in bit 8 on subtract.
- cmd_* is sampled only on the handshake cycle. Changes while cmd_ready=0 are ignored.

## Timing
- Reset state (asynchronous, immediate):
  - state=IDLE.
  - alu_a=0, alu_b=0, alu_sel=0.
  - rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_zero=0, rsp_err=0.
  - ops_done=0.
  - cmd_ready=0 while rst is high, 1 in the first cycle after release.
- Latency: a cmd handshake in cycle N gives rsp_valid high in cycle N+2+ALU_LAT.
- Throughput with rsp_ready held high: one command per 2+ALU_LAT cycles.
- Reset in EXEC or RESP: the in-flight command is dropped, no response is produced, ops_done is cleared.
- alu_* outputs change only on the cmd handshake edge and stay stable for the whole EXEC and RESP period.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD=4'b0000 … OP_EQ=4'b1111, including OP_DIV=4'b0011;
  - the 2-bit FSM state encoding (IDLE, EXEC, RESP);
  - the DIV0_RESULT=9'h1FF constant.
- Single module, no sub-modules. The ALU is instantiated beside it at the parent level, not inside.

## Test plan
- ADD 200+100, tag 3, ALU_LAT=0, cmd handshake at cycle N -> rsp_valid at N+2, rsp_result=9'd300, rsp_tag=3, rsp_zero=0, rsp_err=0.
- SUB 5-5 -> rsp_result=0, rsp_zero=1. SUB 3-5 -> rsp_result=9'h1FE, rsp_zero=0.
- DIV 50/0 -> rsp_result=9'h1FF, rsp_err=1. The next command, DIV 50/7, returns 7 with rsp_err=0.
- Ten back-to-back commands, rsp_ready held high -> one response every 2 cycles, tags in order, ops_done=10.
- Hold rsp_ready low for 5 cycles during RESP -> rsp_* stable, cmd_ready=0, no extra ops_done increment. On release, the accepted next command's response arrives 2 cycles later.
- Assert rst in the middle of EXEC with ALU_LAT=2 -> all outputs go to reset values immediately, no rsp_valid afterwards, cmd_ready=1 in the first cycle after release.
